systolic_ctrl: RTL and testbench

Sequencing controller for the SYS_ROW×SYS_COL systolic PE array and its AXI write-data drain path. It accepts one tile command and clears the PE accumulators. It then streams k_len operand beats into the array under a valid/ready handshake, flushes the skewed wavefront with zero operands, and finally walks write_index over every PE result while driving axi_wvalid against M_AXI_WREADY. It sits between the operand buffers, the array, and the AXI master write channel.

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/systolic_drain_ctr.sv | 48 ++++
 rtl/systolic_ctrl.sv | 143 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, size limits and derived-parameter helpers for the systolic
// array sequencing controller and its write-data drain counter.
package systolic_pkg;

    localparam int SYS_ROW_DEF = 9;
    localparam int SYS_COL_DEF = 9;
    localparam int K_W_DEF     = 16;

    // write_index is 8 bits wide, so the array can hold at most 256 PE results.
    localparam int IDX_W     = 8;
    localparam int MAX_INDEX = (1 << IDX_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Zero-operand cycles needed to push the skewed wavefront out of the array.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    function automatic bit array_fits(input int rows, input int cols);
        return (rows >= 1) && (cols >= 1) && (rows * cols - 1 <= MAX_INDEX);
    endfunction

endpackage

// File: rtl/systolic_drain_ctr.sv
// Write-data beat counter: walks the flat PE result index while enabled,
// holding index and wlast steady whenever the write channel stalls.
module systolic_drain_ctr
    import systolic_pkg::*;
#(
    parameter int TOTAL = SYS_ROW_DEF * SYS_COL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wready,
    output logic             wvalid,
    output logic             wlast,
    output logic             last_beat,
    output logic [IDX_W-1:0] index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    logic [IDX_W-1:0] wr_cnt_q;
    logic [IDX_W-1:0] wr_cnt_d;
    logic             at_last;

    always_comb begin
        at_last  = (wr_cnt_q == LAST_IDX);
        wr_cnt_d = wr_cnt_q;
        // Parked at zero whenever disabled so every drain starts at index 0.
        if (!en) begin
            wr_cnt_d = '0;
        end else if (wready) begin
            wr_cnt_d = at_last ? '0 : wr_cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wvalid    = en;
    assign wlast     = en && at_last;
    assign last_beat = en && at_last && wready;
    assign index     = wr_cnt_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic PE array: clear, operand feed, wavefront
// flush, then AXI write-data drain of every PE result.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int SYS_ROW   = SYS_ROW_DEF,
    parameter int SYS_COL   = SYS_COL_DEF,
    parameter int K_W       = K_W_DEF,
    parameter int FLUSH_LEN = flush_len(SYS_ROW, SYS_COL)
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESETN,
    input  logic             start,
    input  logic [K_W-1:0]   k_len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             pe_clear,
    output logic             pe_en,
    output logic             zero_feed,
    input  logic             M_AXI_WREADY,
    output logic             axi_wvalid,
    output logic [IDX_W-1:0] write_index,
    output logic             wlast,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam int              FL_W       = $clog2(FLUSH_LEN + 1);
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_LEN - 1);

    if (!array_fits(SYS_ROW, SYS_COL)) begin : g_size_check
        $error("systolic_ctrl: SYS_ROW*SYS_COL must be between 1 and 256");
    end

    state_t          state_q, state_d;
    logic [K_W-1:0]  k_len_q, k_len_d;
    logic [K_W-1:0]  feed_cnt_q, feed_cnt_d;
    logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            cmd_err_q, cmd_err_d;
    logic            drain_en;
    logic            drain_last_beat;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        feed_cnt_d  = feed_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cmd_err_d   = 1'b0;
        op_ready    = 1'b0;
        pe_clear    = 1'b0;
        pe_en       = 1'b0;
        zero_feed   = 1'b0;
        drain_en    = 1'b0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_len_d = k_len;
                        state_d = ST_CLEAR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                pe_clear    = 1'b1;
                feed_cnt_d  = '0;
                flush_cnt_d = '0;
                state_d     = ST_FEED;
            end
            ST_FEED: begin
                // The array advances only on an accepted beat; no bubble otherwise.
                op_ready = 1'b1;
                pe_en    = op_valid;
                if (op_valid) begin
                    feed_cnt_d = feed_cnt_q + K_W'(1);
                    if (feed_cnt_q == k_len_q - K_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                pe_en     = 1'b1;
                zero_feed = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            ST_DRAIN: begin
                drain_en = 1'b1;
                if (drain_last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            feed_cnt_q  <= '0;
            flush_cnt_q <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            feed_cnt_q  <= feed_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;

    systolic_drain_ctr #(
        .TOTAL(SYS_ROW * SYS_COL)
    ) u_drain (
        .clk      (M_AXI_ACLK),
        .rst_n    (M_AXI_ARESETN),
        .en       (drain_en),
        .wready   (M_AXI_WREADY),
        .wvalid   (axi_wvalid),
        .wlast    (wlast),
        .last_beat(drain_last_beat),
        .index    (write_index)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: table-driven tiles, hand-written corner sequences
// and randomized tiles checked against a phase-interval reference model.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int ROWS  = 9;
    localparam int COLS  = 9;
    localparam int KW    = 16;
    localparam int FL    = ROWS + COLS - 1;
    localparam int TOTAL = ROWS * COLS;
    localparam int PAT_N = 512;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          op_valid;
    logic          op_ready;
    logic          pe_clear;
    logic          pe_en;
    logic          zero_feed;
    logic          wready;
    logic          axi_wvalid;
    logic [7:0]    write_index;
    logic          wlast;
    logic          busy;
    logic          done;
    logic          cmd_err;

    int checks = 0;
    int fails  = 0;

    bit ov_pat [PAT_N];
    bit wr_pat [PAT_N];

    typedef struct {
        int k;
        int ov_mode;
        int wr_mode;
        int xs_c;
        int xs_k;
        int exp_done;
    } vec_t;

    vec_t vecs [5];

    systolic_ctrl #(
        .SYS_ROW(ROWS),
        .SYS_COL(COLS),
        .K_W    (KW)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .start        (start),
        .k_len        (k_len),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .pe_clear     (pe_clear),
        .pe_en        (pe_en),
        .zero_feed    (zero_feed),
        .M_AXI_WREADY (wready),
        .axi_wvalid   (axi_wvalid),
        .write_index  (write_index),
        .wlast        (wlast),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {busy, pe_clear, op_ready, pe_en, zero_feed, axi_wvalid, wlast, done, cmd_err};
    endfunction

    task automatic check(input string name, input int c, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h", name, c, got, exp);
        end
    endtask

    task automatic fill(input int ov_mode, input int wr_mode);
        for (int i = 0; i < PAT_N; i++) begin
            ov_pat[i] = (ov_mode == 0) ? 1'b1 : (i % 2 == 0);
            wr_pat[i] = (wr_mode == 0) ? 1'b1 : (i % 3 != 0);
        end
    endtask

    // Reference model: derive the phase boundaries from the stimulus patterns
    // (k_len-th accepted operand ends the feed, flush is FL cycles, drain ends
    // on the TOTAL-th accepted beat), then compare every cycle against them.
    task automatic run_tile(input int k, input int xs_c, input logic [KW-1:0] xs_k,
                            input int exp_done, input string tag);
        int t, ds, u, cnt, run_idx, done_at, beats;
        bit in_feed, in_fl, in_dr;
        logic [8:0] exp;
        t = -1;
        cnt = 0;
        for (int i = 2; i < PAT_N - 4 && t < 0; i++) begin
            cnt += int'(ov_pat[i]);
            if (cnt == k) t = i;
        end
        u = -1;
        ds = t + FL + 1;
        cnt = 0;
        if (t >= 0) begin
            for (int i = ds; i < PAT_N - 4 && u < 0; i++) begin
                cnt += int'(wr_pat[i]);
                if (cnt == TOTAL) u = i;
            end
        end
        if (u < 0) begin
            checks++;
            fails++;
            $display("FAIL %s model_budget got -1 expected a completed tile", tag);
            return;
        end
        run_idx = 0;
        done_at = -1;
        beats   = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        k_len    = KW'(k);
        op_valid = 1'b0;
        wready   = 1'b0;
        for (int c = 1; c <= u + 2; c++) begin
            @(posedge clk);
            #1;
            start    = (c == xs_c);
            k_len    = (c == xs_c) ? xs_k : KW'($urandom);
            op_valid = ov_pat[c];
            wready   = wr_pat[c];
            @(negedge clk);
            in_feed = (c >= 2) && (c <= t);
            in_fl   = (c > t) && (c <= t + FL);
            in_dr   = (c >= ds) && (c <= u);
            exp = {c <= u + 1, c == 1, in_feed, (in_feed && ov_pat[c]) || in_fl, in_fl,
                   in_dr, in_dr && (run_idx == TOTAL - 1), c == u + 1, 1'b0};
            check({tag, "_outs"}, c, outs(), exp);
            if (in_dr) begin
                check({tag, "_write_index"}, c, write_index, run_idx);
                if (wr_pat[c]) run_idx++;
            end
            if (axi_wvalid && wready) beats++;
            if (done && done_at < 0) done_at = c;
        end
        start    = 1'b0;
        op_valid = 1'b0;
        wready   = 1'b0;
        check({tag, "_done_cycle"}, 0, done_at, (exp_done > 0) ? exp_done : u + 1);
        check({tag, "_beats"}, 0, beats, TOTAL);
    endtask

    initial begin
        vecs[0] = '{k: 4, ov_mode: 0, wr_mode: 0, xs_c: 0,   xs_k: 0, exp_done: 104};
        vecs[1] = '{k: 1, ov_mode: 0, wr_mode: 0, xs_c: 0,   xs_k: 0, exp_done: 101};
        vecs[2] = '{k: 4, ov_mode: 1, wr_mode: 1, xs_c: 0,   xs_k: 0, exp_done: 147};
        vecs[3] = '{k: 3, ov_mode: 0, wr_mode: 0, xs_c: 3,   xs_k: 7, exp_done: 103};
        vecs[4] = '{k: 2, ov_mode: 0, wr_mode: 0, xs_c: 102, xs_k: 5, exp_done: 102};

        rst_n    = 1'b0;
        start    = 1'b0;
        k_len    = '0;
        op_valid = 1'b0;
        wready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: noise on the data-side inputs must not wake it.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            op_valid = 1'($urandom);
            wready   = 1'($urandom);
            k_len    = KW'($urandom);
            @(negedge clk);
            check("idle", c, {outs(), write_index}, 17'd0);
        end

        // Zero-length command: single cmd_err pulse, never leaves IDLE.
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        k_len = KW'($urandom);
        @(negedge clk);
        check("kzero_pulse", 1, outs(), 9'b0_0000_0001);
        @(posedge clk);
        @(negedge clk);
        check("kzero_after", 2, outs(), 9'd0);

        foreach (vecs[i]) begin
            fill(vecs[i].ov_mode, vecs[i].wr_mode);
            run_tile(vecs[i].k, vecs[i].xs_c, KW'(vecs[i].xs_k), vecs[i].exp_done,
                     $sformatf("vec%0d", i));
        end

        // Reset during drain beat 40: k_len=2, all ready, drain starts at cycle 21.
        fill(0, 0);
        @(posedge clk);
        #1;
        start    = 1'b1;
        k_len    = 16'd2;
        op_valid = 1'b1;
        wready   = 1'b1;
        for (int c = 1; c <= 61; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
        end
        check("mid_drain_beat", 61, {axi_wvalid, write_index}, {1'b1, 8'd40});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_valid = 1'b0;
        wready   = 1'b0;
        @(negedge clk);
        check("reset_abort", 62, {outs(), write_index}, 17'd0);
        run_tile(1, 0, '0, 101, "after_reset");

        for (int r = 0; r < 6; r++) begin
            int k;
            int xs_c;
            logic [KW-1:0] xs_k;
            k = int'($urandom_range(1, 8));
            for (int i = 0; i < PAT_N; i++) begin
                ov_pat[i] = ($urandom_range(0, 99) < 60);
                wr_pat[i] = ($urandom_range(0, 99) < 70);
            end
            xs_c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0;
            xs_k = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom);
            run_tile(k, xs_c, xs_k, 0, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
